// File: rtl/databus_arbiter_if.sv
// Request/grant bundle between the control unit's gate requests and the data bus arbiter.
// The master side raises requests; the slave side (the arbiter) returns grant, select and status.
interface databus_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       bus_valid;
  logic       timeout;

  modport master (output req, input grant, select, bus_valid, timeout);
  modport slave  (input req, output grant, select, bus_valid, timeout);
endinterface

// File: rtl/databus_arbiter.sv
// Round-robin arbiter for the 16-bit internal data bus (MARMUX, PC, ALU, MDR).
// Registered one-hot grant and mux select, one-cycle turnaround, bounded hold per grant.
module databus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  databus_arbiter_if.slave   bus
);

  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t         state_q;
  logic [1:0]     ptr_q;
  logic [1:0]     select_q;
  logic [HCW-1:0] hold_q;
  logic [3:0]     mask_q;
  logic [3:0]     mask_d;
  logic [3:0]     grant_q;
  logic           valid_q;
  logic           timeout_q;

  logic [3:0]     elig;
  logic [1:0]     cand;
  logic [1:0]     win;
  logic           win_found;
  logic           owner_req;
  logic           hold_max;

  // select_q doubles as the owner index while in OWN.
  always_comb begin
    elig      = bus.req & ~mask_q;
    cand      = '0;
    win       = ptr_q;
    win_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && elig[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
    owner_req = bus.req[select_q];
    hold_max  = (hold_q == HCW'(MAX_HOLD));
    mask_d    = mask_q & bus.req;
    if (state_q == OWN && owner_req && hold_max) begin
      mask_d[select_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      select_q  <= '0;
      hold_q    <= '0;
      mask_q    <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (win_found) begin
          grant_q  <= 4'b0001 << win;
          select_q <= win;
          valid_q  <= 1'b1;
          hold_q   <= HCW'(1);
          ptr_q    <= win + 2'd1;
          state_q  <= OWN;
        end
      end else begin
        // A drop on the MAX_HOLD cycle is an ordinary release: no timeout, no mask.
        if (!owner_req || hold_max) begin
          grant_q   <= '0;
          valid_q   <= 1'b0;
          hold_q    <= '0;
          timeout_q <= owner_req;
          state_q   <= IDLE;
        end else begin
          hold_q <= hold_q + HCW'(1);
        end
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.select    = select_q;
  assign bus.bus_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: doc/databus_arbiter.md
Name: databus_arbiter

Overview:
- Round-robin arbiter that shares the 16-bit internal data bus between its four drivers: MARMUX, PC, ALU and MDR.
- Produces the registered 2-bit source select that steers the bus mux, plus a one-hot grant back to each requester.
- Enforces a one-cycle turnaround between owners and a bounded hold time per grant.
- Sits between the control unit's gate requests and the data bus mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one requester may own the bus. Legal range 1..255.
- HCW, $clog2(MAX_HOLD+1): hold counter width, derived; not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  bus requests. bit0 MARMUX, bit1 PC, bit2 ALU, bit3 MDR.
- grant  output  4  one-hot grant, registered.
- select  output  2  bus mux select: 00 MARMUX, 01 PC, 10 ALU, 11 MDR. Registered.
- bus_valid  output  1  high while any grant is active; the bus value is meaningful only then.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: grant=0000, select=00, bus_valid=0, timeout=0.
  - Internal: state=IDLE, priority pointer=0, hold counter=0, timeout mask=0000.
- States: IDLE and OWN.
- IDLE:
  - Eligible requests are req & ~mask.
  - If any request is eligible, pick the first set bit searching from the pointer upward, wrapping 3->0.
  - On that edge: grant=onehot(winner), select=winner index, bus_valid=1, hold=1, state->OWN, pointer=(winner+1) mod 4.
  - Latency: a request sampled at edge k is granted in the cycle after edge k.
  - If nothing is eligible: outputs stay grant=0, bus_valid=0, select holds its last value.
- OWN, owner o:
  - If req[o]=0: release on the next edge. grant=0, bus_valid=0, state->IDLE.
  - Else if hold==MAX_HOLD: forced release. grant=0, bus_valid=0, timeout=1 for exactly one cycle, mask[o]=1, state->IDLE.
  - Else: hold stays granted, hold+=1.
  - Other requesters' activity is ignored while in OWN; there is no preemption.
- Turnaround: every release passes through at least one IDLE cycle with bus_valid=0. Back-to-back grants without a gap are forbidden.
- Mask: mask[i] clears on any edge where req[i]=0. A timed-out requester must drop req for at least one cycle before it is eligible again.
- Invariants: grant is always one-hot or zero; bus_valid == |grant; select == index of grant whenever bus_valid=1.
- Simultaneous events:
  - req[o] drops on the same cycle hold reaches MAX_HOLD: normal release, no timeout, no mask.
  - New requests arriving during the release edge are evaluated in the following IDLE cycle.
- Reset mid-grant: outputs drop to reset values immediately (async). The pointer returns to 0, so MARMUX has top priority after release.
- With MAX_HOLD=1 every grant lasts exactly one cycle. timeout fires if req[o] is still high after that cycle.

Test Plan:
- Reset: hold reset_n=0 while driving req=1111. Required: grant=0000, bus_valid=0, timeout=0 throughout. Release reset; first grant is 0001 with select=00, one cycle later.
- Single request: req=0100 held 3 cycles, then dropped. Required: grant=0100, select=10 for 3 cycles, then grant=0000 on the edge after the drop.
- Round-robin: req=1111 held continuously, owner drops each req after 2 granted cycles and re-raises it. Required grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one bus_valid=0 cycle.
- Timeout with MAX_HOLD=4: req=0010 held indefinitely.
  - Required: grant 0010 for 4 cycles, then release with timeout=1 for one cycle.
  - No regrant to PC until req[1] goes low for a cycle and returns.
  - Meanwhile req[3] raised is granted (1000, select=11) after the turnaround.
- Reset mid-grant: while ALU owns the bus on its 2nd cycle, pulse reset_n low between clock edges. Required: grant=0000 and bus_valid=0 before the next edge. After release with req=1100, the grant goes to ALU (0100) because the pointer is back at 0.
- Boundary: req[o] drops exactly on the MAX_HOLD cycle. Required: normal release, timeout stays 0, and the requester is immediately eligible again.
